vga_scan_gen: RTL and testbench

//  - Produces the raster scan that all draw_* object modules consume: pix_x/pix_y, hsync/vsync, display_on.
//  - Includes line/frame strobes for game-state update logic.
//  - Sits in tt_um_example between the pixel clock and the object/colour mux.
//  - Default timing is 640x480@60 (800x525 total).

---
 rtl/vga_scan_gen_pkg.sv | 24 ++
 rtl/vga_scan_gen_if.sv | 27 ++
 rtl/vga_scan_gen_axis.sv | 73 +++++++
 rtl/vga_scan_gen.sv | 74 +++++++
 tb/tb_vga_scan_gen.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/vga_scan_gen_pkg.sv
// Shared raster types and the default 640x480@60 timing (800x525 total) for the VGA scan generator.
package vga_timing_pkg;
   localparam int unsigned COORD_W   = 10;
   localparam int unsigned COORD_MAX = 1 << COORD_W;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FRONT  = 2'd1,
      SYNC   = 2'd2,
      BACK   = 2'd3
   } scan_phase_t;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FRONT_DEF  = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BACK_DEF   = 48;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FRONT_DEF  = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BACK_DEF   = 33;
   localparam bit          SYNC_POL_DEF = 1'b0;
endpackage

// File: rtl/vga_scan_gen_if.sv
// Raster bundle between the scan generator (master) and the draw/colour logic (slave).
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_scan_if;
   import vga_timing_pkg::*;

   logic   tick;
   coord_t pix_x;
   coord_t pix_y;
   logic   hsync;
   logic   vsync;
   logic   display_on;
   logic   line_start;
   logic   frame_start;
`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame_cnt;

   modport master (input tick, output pix_x, pix_y, hsync, vsync, display_on,
                   line_start, frame_start, frame_cnt);
   modport slave  (output tick, input pix_x, pix_y, hsync, vsync, display_on,
                   line_start, frame_start, frame_cnt);
`else
   modport master (input tick, output pix_x, pix_y, hsync, vsync, display_on,
                   line_start, frame_start);
   modport slave  (output tick, input pix_x, pix_y, hsync, vsync, display_on,
                   line_start, frame_start);
`endif
endinterface

// File: rtl/vga_scan_gen_axis.sv
// One raster axis: coordinate counter with its blanking-phase FSM and registered sync decode.
//   state     | meaning
//   ST_ACTIVE | visible pixels/lines
//   ST_FRONT  | front porch
//   ST_SYNC   | sync pulse, sync_o at SYNC_POL
//   ST_BACK   | back porch (also the reset state, counter at TOTAL-1)
module scan_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE_LEN = H_ACTIVE_DEF,
   parameter int unsigned FRONT_LEN  = H_FRONT_DEF,
   parameter int unsigned SYNC_LEN   = H_SYNC_DEF,
   parameter int unsigned BACK_LEN   = H_BACK_DEF,
   parameter bit          SYNC_POL   = SYNC_POL_DEF
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   step_i,
   output coord_t cnt_o,
   output logic   sync_o,
   output logic   active_nxt_o,
   output logic   wrap_o
);
   localparam int unsigned TOTAL   = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
   localparam coord_t      LAST    = coord_t'(TOTAL - 1);
   localparam coord_t      B_FRONT = coord_t'(ACTIVE_LEN);
   localparam coord_t      B_SYNC  = coord_t'(ACTIVE_LEN + FRONT_LEN);
   localparam coord_t      B_BACK  = coord_t'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);

   localparam logic [1:0] ST_ACTIVE = ACTIVE;
   localparam logic [1:0] ST_FRONT  = FRONT;
   localparam logic [1:0] ST_SYNC   = SYNC;
   localparam logic [1:0] ST_BACK   = BACK;

   if (TOTAL > COORD_MAX) begin : g_bad_total
      $error("scan_axis_counter: total of %0d exceeds the 10-bit coordinate range", TOTAL);
   end

   coord_t     cnt_q, cnt_d;
   logic [1:0] phase_q, phase_d;
   logic       sync_q, sync_d;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (step_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + coord_t'(1);
         if (cnt_d == '0)           phase_d = ST_ACTIVE;
         else if (cnt_d == B_FRONT) phase_d = ST_FRONT;
         else if (cnt_d == B_SYNC)  phase_d = ST_SYNC;
         else if (cnt_d == B_BACK)  phase_d = ST_BACK;
      end
      sync_d = (phase_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= LAST;
         phase_q <= ST_BACK;
         sync_q  <= ~SYNC_POL;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         sync_q  <= sync_d;
      end
   end

   // The top registers display_on from the next phase so it lines up with cnt_q.
   assign active_nxt_o = (phase_d == ST_ACTIVE);
   assign wrap_o       = step_i && (cnt_q == LAST);
   assign cnt_o        = cnt_q;
   assign sync_o       = sync_q;
endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel/line counters, syncs, display enable and line/frame strobes.
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_scan_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FRONT  = H_FRONT_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BACK   = H_BACK_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FRONT  = V_FRONT_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BACK   = V_BACK_DEF,
   parameter bit          SYNC_POL = SYNC_POL_DEF
) (
   input logic        clk,
   input logic        rst_n,
   vga_scan_if.master scan
);
   coord_t h_cnt, v_cnt;
   logic   h_sync, v_sync;
   logic   h_act_nxt, v_act_nxt;
   logic   h_wrap, v_wrap, v_step;
   logic   display_on_q, line_start_q, frame_start_q;

   assign v_step = scan.tick & h_wrap;

   scan_axis_counter #(
      .ACTIVE_LEN(H_ACTIVE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK),
      .SYNC_POL(SYNC_POL)
   ) u_h (
      .clk(clk), .rst_n(rst_n), .step_i(scan.tick), .cnt_o(h_cnt), .sync_o(h_sync),
      .active_nxt_o(h_act_nxt), .wrap_o(h_wrap)
   );

   scan_axis_counter #(
      .ACTIVE_LEN(V_ACTIVE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK),
      .SYNC_POL(SYNC_POL)
   ) u_v (
      .clk(clk), .rst_n(rst_n), .step_i(v_step), .cnt_o(v_cnt), .sync_o(v_sync),
      .active_nxt_o(v_act_nxt), .wrap_o(v_wrap)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         display_on_q  <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         display_on_q  <= h_act_nxt & v_act_nxt;
         line_start_q  <= h_wrap;
         frame_start_q <= h_wrap & v_wrap;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                frame_cnt_q <= '0;
      else if (h_wrap & v_wrap)  frame_cnt_q <= frame_cnt_q + 8'd1;
   end

   assign scan.frame_cnt = frame_cnt_q;
`endif

   assign scan.pix_x       = h_cnt;
   assign scan.pix_y       = v_cnt;
   assign scan.hsync       = h_sync;
   assign scan.vsync       = v_sync;
   assign scan.display_on  = display_on_q;
   assign scan.line_start  = line_start_q;
   assign scan.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench: a default-timing and a reduced-timing instance share one random tick stream.
module tb_vga_scan_gen;
   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       de;
      logic       ls;
      logic       fs;
      logic [7:0] fc;
   } obs_t;

   typedef struct packed {
      obs_t d;
      obs_t s;
   } exp_t;

   localparam int SHA = 6, SHF = 1, SHS = 2, SHB = 1;
   localparam int SVA = 4, SVF = 1, SVS = 1, SVB = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic tick;
   int   t;
   int   hold_left;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   started = 1'b0;
   exp_t q[$];

   always #5 clk = ~clk;

   vga_scan_if u_if_def ();
   vga_scan_if u_if_sm ();
   assign u_if_def.tick = tick;
   assign u_if_sm.tick  = tick;

   vga_scan_gen u_def (.clk(clk), .rst_n(rst_n), .scan(u_if_def));

   vga_scan_gen #(
      .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
      .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_POL(1'b1)
   ) u_sm (.clk(clk), .rst_n(rst_n), .scan(u_if_sm));

   // Position after t ticks since reset: reset sits on the last pixel of the frame.
   function automatic obs_t model(int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb,
                                  bit pol, int tt, bit ticked);
      obs_t o;
      int ht, vt, ft, pos, x, y;
      ht  = ha + hf + hs + hb;
      vt  = va + vf + vs + vb;
      ft  = ht * vt;
      pos = (tt + ft - 1) % ft;
      x   = pos % ht;
      y   = pos / ht;
      o.x  = 10'(x);
      o.y  = 10'(y);
      o.hs = (x >= ha + hf && x < ha + hf + hs) ? pol : !pol;
      o.vs = (y >= va + vf && y < va + vf + vs) ? pol : !pol;
      o.de = (x < ha) && (y < va);
      o.ls = ticked && (x == 0);
      o.fs = ticked && (x == 0) && (y == 0);
`ifdef VGA_FRAME_CNT_EN
      o.fc = (tt == 0) ? 8'd0 : 8'(((tt - 1) / ft + 1) % 256);
`else
      o.fc = 8'd0;
`endif
      return o;
   endfunction

   function automatic exp_t expect_now(int tt, bit ticked);
      exp_t e;
      e.d = model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, tt, ticked);
      e.s = model(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1, tt, ticked);
      return e;
   endfunction

   function automatic obs_t obs_def();
      obs_t o;
      o = {u_if_def.pix_x, u_if_def.pix_y, u_if_def.hsync, u_if_def.vsync,
           u_if_def.display_on, u_if_def.line_start, u_if_def.frame_start, 8'd0};
`ifdef VGA_FRAME_CNT_EN
      o.fc = u_if_def.frame_cnt;
`endif
      return o;
   endfunction

   function automatic obs_t obs_sm();
      obs_t o;
      o = {u_if_sm.pix_x, u_if_sm.pix_y, u_if_sm.hsync, u_if_sm.vsync,
           u_if_sm.display_on, u_if_sm.line_start, u_if_sm.frame_start, 8'd0};
`ifdef VGA_FRAME_CNT_EN
      o.fc = u_if_sm.frame_cnt;
`endif
      return o;
   endfunction

   task automatic check(string nm, obs_t got, obs_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d required x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                  nm, $time, got.x, got.y, got.hs, got.vs, got.de, got.ls, got.fs, got.fc,
                  exp.x, exp.y, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.fc);
      end
   endtask

   // Drive one cycle of stimulus at a falling edge and queue what the next rising edge must show.
   task automatic drive_cycle();
      if (hold_left > 0) begin
         tick = 1'b0;
         hold_left--;
      end else if ($urandom_range(0, 199) == 0) begin
         tick      = 1'b0;
         hold_left = 9;
      end else begin
         tick = ($urandom_range(0, 9) < 8);
      end
      if (tick) t++;
      q.push_back(expect_now(t, tick));
   endtask

   task automatic run(int cycles);
      for (int i = 0; i < cycles; i++) begin
         drive_cycle();
         @(negedge clk);
      end
   endtask

   task automatic async_reset();
      exp_t e;
      tick = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      e = expect_now(0, 1'b0);
      check("async_reset_def", obs_def(), e.d);
      check("async_reset_sm", obs_sm(), e.s);
      t = 0;
      q.push_back(e);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      wait (started);
      forever begin
         @(posedge clk);
         #1;
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_underflow @%0t got empty queue required one entry", $time);
         end else begin
            e = q.pop_front();
            check("scan_def", obs_def(), e.d);
            check("scan_sm", obs_sm(), e.s);
         end
      end
   end

   initial begin : driver
      exp_t e;
      rst_n     = 1'b0;
      tick      = 1'b0;
      t         = 0;
      hold_left = 0;
      repeat (3) @(posedge clk);
      #1;
      e = expect_now(0, 1'b0);
      check("reset_def", obs_def(), e.d);
      check("reset_sm", obs_sm(), e.s);
      @(negedge clk);
      rst_n   = 1'b1;
      started = 1'b1;
      run(3000);
      async_reset();
      run(27000);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain got %0d entries left required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
